// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants, memory-stage state type and store-lane helpers.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;

  // Everything about an accepted access needed again when the ack returns.
  typedef struct packed {
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic        is_store;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic [31:0] iw;
    logic [31:0] pc;
  } mem_hold_t;

  function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] alo);
    case (f3)
      F3_B, F3_BU: be_for = 4'b0001 << alo;
      F3_H, F3_HU: be_for = 4'b0011 << alo;
      default:     be_for = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_for(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    wdata_for = {4{d[7:0]}};
      F3_H:    wdata_for = {2{d[15:0]}};
      default: wdata_for = d;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a load word and extends it.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  f3_i,
  input  logic [1:0]  alo_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  assign sh = rdata_i >> {alo_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (f3_i)
      F3_B:    data_o = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data_o = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   data_o = {24'd0, sh[7:0]};
      F3_HU:   data_o = {16'd0, sh[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: single-cycle pass-through, or one outstanding req/ack
// data-memory access with ack timeout, feeding writeback and decode forwarding.
module mem_stage
  import rv32_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int DMEM_AW     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [31:0]        alu_in,
  input  logic [31:0]        iw_in,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        rs2_data_in,
  input  logic               w_en_in,
  input  logic [4:0]         wb_reg_in,
  input  logic               wb_en_in,
  output logic               stall_out,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_ack,
  output logic               valid_out,
  output logic [31:0]        iw_out,
  output logic [31:0]        pc_out,
  output logic [31:0]        wb_data_out,
  output logic [4:0]         wb_reg_out,
  output logic               wb_en_out,
  output logic               misalign_out,
  output logic               bus_err_out,
  output logic               df_mem_enable,
  output logic [4:0]         df_mem_reg,
  output logic [31:0]        df_mem_data
);

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  mem_state_e         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [DMEM_AW-1:0] addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  mem_hold_t          hold_q, hold_d;
  logic               vld_q, vld_d;
  logic [31:0]        iw_q, iw_d, pc_q, pc_d, wbd_q, wbd_d;
  logic [4:0]         wbr_q, wbr_d;
  logic               wbe_q, wbe_d, mis_q, mis_d, berr_q, berr_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [1:0]  alo;
  logic        is_load, is_store, is_mem, misal;
  logic [31:0] ld_data;

  assign opc = iw_in[6:0];
  assign f3  = iw_in[14:12];
  assign alo = alu_in[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opc == OP_LOAD)
      is_load = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    if (opc == OP_STORE && w_en_in)
      is_store = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  end

  assign is_mem = is_load | is_store;
  assign misal  = (((f3 == F3_H) || (f3 == F3_HU)) && alo[0]) ||
                  ((f3 == F3_W) && (alo != 2'b00));

  load_align u_load_align (
    .rdata_i (mem_rdata),
    .f3_i    (hold_q.f3),
    .alo_i   (hold_q.alo),
    .data_o  (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    vld_d   = 1'b0;
    iw_d    = iw_q;
    pc_d    = pc_q;
    wbd_d   = wbd_q;
    wbr_d   = wbr_q;
    wbe_d   = wbe_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (valid_in) begin
          if (!is_mem) begin
            vld_d = 1'b1;
            iw_d  = iw_in;
            pc_d  = pc_in;
            wbd_d = alu_in;
            wbr_d = wb_reg_in;
            wbe_d = wb_en_in;
          end else if (misal) begin
            mis_d = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = 8'd0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {alu_in[DMEM_AW-1:2], 2'b00};
            be_d    = be_for(f3, alo);
            wdata_d = wdata_for(f3, rs2_data_in);
            hold_d  = '{f3: f3, alo: alo, is_store: is_store, wb_reg: wb_reg_in,
                        wb_en: wb_en_in, iw: iw_in, pc: pc_in};
          end
        end
      end
      MEM_WAIT: begin
        // Ack is tested first so it beats a timeout landing on the same cycle.
        if (mem_ack) begin
          state_d = MEM_IDLE;
          req_d   = 1'b0;
          vld_d   = 1'b1;
          iw_d    = hold_q.iw;
          pc_d    = hold_q.pc;
          wbr_d   = hold_q.wb_reg;
          wbe_d   = hold_q.wb_en & ~hold_q.is_store;
          wbd_d   = hold_q.is_store ? 32'd0 : ld_data;
        end else if (cnt_q == TO_LAST) begin
          state_d = MEM_IDLE;
          req_d   = 1'b0;
          berr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      iw_q    <= 32'd0;
      pc_q    <= 32'd0;
      wbd_q   <= 32'd0;
      wbr_q   <= 5'd0;
      wbe_q   <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      iw_q    <= iw_d;
      pc_q    <= pc_d;
      wbd_q   <= wbd_d;
      wbr_q   <= wbr_d;
      wbe_q   <= wbe_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign stall_out     = (state_q == MEM_WAIT);
  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_be        = be_q;
  assign mem_wdata     = wdata_q;
  assign valid_out     = vld_q;
  assign iw_out        = iw_q;
  assign pc_out        = pc_q;
  assign wb_data_out   = wbd_q;
  assign wb_reg_out    = wbr_q;
  assign wb_en_out     = wbe_q;
  assign misalign_out  = mis_q;
  assign bus_err_out   = berr_q;
  assign df_mem_enable = vld_q & wbe_q & (wbr_q != 5'd0);
  assign df_mem_reg    = wbr_q;
  assign df_mem_data   = wbd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads/stores, misalign, timeout, reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] alu_in = '0, iw_in = '0, pc_in = '0, rs2_data_in = '0;
  logic        w_en_in = 1'b0;
  logic [4:0]  wb_reg_in = '0;
  logic        wb_en_in = 1'b0;
  logic        stall_out, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        valid_out;
  logic [31:0] iw_out, pc_out, wb_data_out;
  logic [4:0]  wb_reg_out;
  logic        wb_en_out, misalign_out, bus_err_out, df_mem_enable;
  logic [4:0]  df_mem_reg;
  logic [31:0] df_mem_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.ACK_TIMEOUT(16), .DMEM_AW(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_in(alu_in), .iw_in(iw_in),
    .pc_in(pc_in), .rs2_data_in(rs2_data_in), .w_en_in(w_en_in), .wb_reg_in(wb_reg_in),
    .wb_en_in(wb_en_in), .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .valid_out(valid_out), .iw_out(iw_out), .pc_out(pc_out),
    .wb_data_out(wb_data_out), .wb_reg_out(wb_reg_out), .wb_en_out(wb_en_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out), .df_mem_enable(df_mem_enable),
    .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    mk = {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic drive(input logic [31:0] iw, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic wen, input logic [4:0] rd, input logic rd_en);
    valid_in = 1'b1; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
    w_en_in = wen; wb_reg_in = rd; wb_en_in = rd_en; pc_in = pc_in + 32'd4;
  endtask

  task automatic idle();
    valid_in = 1'b0; w_en_in = 1'b0;
  endtask

  // Ack arrives in the n-th WAIT cycle; counts stall cycles seen on the way.
  task automatic wait_ack(input int n, input logic [31:0] rd, output int stalls);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin mem_ack = 1'b1; mem_rdata = rd; end
      if (stall_out) stalls++;
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                      input logic [31:0] exp, input string tag);
    int s;
    drive(mk(7'b0000011, f3), addr, 32'd0, 1'b0, 5'd7, 1'b1);
    step();
    idle();
    wait_ack(2, rd, s);
    chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    chk({tag, "_data"}, wb_data_out, exp);
  endtask

  localparam logic [31:0] ADD = 32'h0000_0033;
  localparam logic [31:0] PC0 = 32'h0000_1000;
  int s, n;

  initial begin
    pc_in = PC0;
    #2;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wbdata", wb_data_out, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // pass-through
    drive(ADD, 32'h1234, 32'd0, 1'b0, 5'd5, 1'b1);
    step();
    idle();
    chk("add_valid", {31'd0, valid_out}, 32'd1);
    chk("add_data", wb_data_out, 32'h1234);
    chk("add_df_en", {31'd0, df_mem_enable}, 32'd1);
    chk("add_df_reg", {27'd0, df_mem_reg}, 32'd5);
    chk("add_pc", pc_out, PC0 + 32'd4);
    chk("add_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("bubble_valid", {31'd0, valid_out}, 32'd0);

    // LB 0x103, ack in third wait cycle
    drive(mk(7'b0000011, 3'b000), 32'h103, 32'd0, 1'b0, 5'd7, 1'b1);
    step();
    idle();
    chk("lb_req", {31'd0, mem_req}, 32'd1);
    chk("lb_be", {28'd0, mem_be}, 32'h8);
    chk("lb_addr", mem_addr, 32'h100);
    chk("lb_we", {31'd0, mem_we}, 32'd0);
    chk("lb_wait_valid", {31'd0, valid_out}, 32'd0);
    wait_ack(3, 32'h80AABBCC, s);
    chk("lb_stalls", s, 32'd3);
    chk("lb_valid", {31'd0, valid_out}, 32'd1);
    chk("lb_data", wb_data_out, 32'hFFFFFF80);
    chk("lb_req_drop", {31'd0, mem_req}, 32'd0);
    chk("lb_stall_rel", {31'd0, stall_out}, 32'd0);

    load(3'b100, 32'h103, 32'h80AABBCC, 32'h00000080, "lbu");
    load(3'b001, 32'h102, 32'h80AABBCC, 32'hFFFF80AA, "lh");
    load(3'b101, 32'h100, 32'h80AABBCC, 32'h0000BBCC, "lhu");
    load(3'b000, 32'h101, 32'h80AABBCC, 32'hFFFFFFBB, "lb1");
    load(3'b010, 32'h104, 32'h12345678, 32'h12345678, "lw");

    // SH 0x202
    drive(mk(7'b0100011, 3'b001), 32'h202, 32'h0000BEEF, 1'b1, 5'd9, 1'b1);
    step();
    idle();
    chk("sh_be", {28'd0, mem_be}, 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("sh_we", {31'd0, mem_we}, 32'd1);
    chk("sh_addr", mem_addr, 32'h200);
    step();
    chk("sh_be_hold", {28'd0, mem_be}, 32'hC);
    wait_ack(1, 32'd0, s);
    chk("sh_valid", {31'd0, valid_out}, 32'd1);
    chk("sh_wben", {31'd0, wb_en_out}, 32'd0);
    chk("sh_df_en", {31'd0, df_mem_enable}, 32'd0);

    // SB 0x001
    drive(mk(7'b0100011, 3'b000), 32'h001, 32'h123456A5, 1'b1, 5'd0, 1'b0);
    step();
    idle();
    chk("sb_be", {28'd0, mem_be}, 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    wait_ack(1, 32'd0, s);

    // STORE opcode without w_en is a pass-through
    drive(mk(7'b0100011, 3'b010), 32'h0000_0AB0, 32'h1, 1'b0, 5'd4, 1'b1);
    step();
    idle();
    chk("st_noen_valid", {31'd0, valid_out}, 32'd1);
    chk("st_noen_data", wb_data_out, 32'h0000_0AB0);
    chk("st_noen_req", {31'd0, mem_req}, 32'd0);

    // misaligned LW and LH
    drive(mk(7'b0000011, 3'b010), 32'h101, 32'd0, 1'b0, 5'd6, 1'b1);
    step();
    idle();
    chk("lw_mis_pulse", {31'd0, misalign_out}, 32'd1);
    chk("lw_mis_valid", {31'd0, valid_out}, 32'd0);
    chk("lw_mis_req", {31'd0, mem_req}, 32'd0);
    step();
    chk("lw_mis_clear", {31'd0, misalign_out}, 32'd0);
    drive(mk(7'b0000011, 3'b001), 32'h103, 32'd0, 1'b0, 5'd6, 1'b1);
    step();
    idle();
    chk("lh_mis_pulse", {31'd0, misalign_out}, 32'd1);
    chk("lh_mis_req", {31'd0, mem_req}, 32'd0);

    // timeout: mem_req high exactly 16 cycles
    drive(mk(7'b0000011, 3'b010), 32'h300, 32'd0, 1'b0, 5'd8, 1'b1);
    step();
    idle();
    n = 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      n++;
      step();
    end
    chk("to_req_cycles", n, 32'd16);
    chk("to_buserr", {31'd0, bus_err_out}, 32'd1);
    chk("to_valid", {31'd0, valid_out}, 32'd0);
    chk("to_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("to_buserr_clr", {31'd0, bus_err_out}, 32'd0);

    // ack on the timeout cycle wins
    drive(mk(7'b0000011, 3'b010), 32'h400, 32'd0, 1'b0, 5'd8, 1'b1);
    step();
    idle();
    wait_ack(16, 32'hCAFEF00D, s);
    chk("race_valid", {31'd0, valid_out}, 32'd1);
    chk("race_data", wb_data_out, 32'hCAFEF00D);
    chk("race_buserr", {31'd0, bus_err_out}, 32'd0);

    // load to x0: access happens, no forwarding
    drive(mk(7'b0000011, 3'b010), 32'h10, 32'd0, 1'b0, 5'd0, 1'b1);
    step();
    idle();
    chk("x0_req", {31'd0, mem_req}, 32'd1);
    wait_ack(1, 32'h5555AAAA, s);
    chk("x0_valid", {31'd0, valid_out}, 32'd1);
    chk("x0_df_en", {31'd0, df_mem_enable}, 32'd0);

    // ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'hDEAD0000;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_valid", {31'd0, valid_out}, 32'd0);
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

    // reset in WAIT_ACK
    drive(mk(7'b0000011, 3'b010), 32'h500, 32'd0, 1'b0, 5'd2, 1'b1);
    step();
    idle();
    step();
    #1 reset = 1'b0;
    #1;
    chk("rst_wait_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wait_stall", {31'd0, stall_out}, 32'd0);
    step();
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    chk("stale_valid", {31'd0, valid_out}, 32'd0);
    drive(ADD, 32'h55, 32'd0, 1'b0, 5'd3, 1'b1);
    step();
    idle();
    mem_ack = 1'b0;
    chk("post_rst_valid", {31'd0, valid_out}, 32'd1);
    chk("post_rst_data", wb_data_out, 32'h55);
    chk("post_rst_req", {31'd0, mem_req}, 32'd0);
    chk("post_rst_reg", {27'd0, df_mem_reg}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
